// File: rtl/video_dram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : video_dram_arb
//  Purpose  : DRAM cycle arbiter between the video fetch port and the CPU
//             port. One 16-bit DRAM access per cycle; cycles are delimited
//             by the one-clk cend strobe and all grant decisions happen on it.
//             Video has fixed priority in its bandwidth slots, the CPU gets
//             every other cycle it asks for.
//  Ports    : clk, rst (sync, active-high), cend
//             video_go/video_bw/video_addr  -> video_next/video_strobe/video_data
//             cpu_req/rnw/addr/bsel/wrdata  -> cpu_next/cpu_strobe/cpu_rddata
//             dram_req/rnw/addr/bsel/wrdata -> DRAM, dram_rddata <- DRAM
//  Revision : 1.0  initial release
// ============================================================================
module video_dram_arb #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cend,
    input  logic              video_go,
    input  logic [1:0]        video_bw,
    input  logic [ADDR_W-1:0] video_addr,
    output logic              video_next,
    output logic              video_strobe,
    output logic [DATA_W-1:0] video_data,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [1:0]        cpu_bsel,
    input  logic [DATA_W-1:0] cpu_wrdata,
    output logic              cpu_next,
    output logic              cpu_strobe,
    output logic [DATA_W-1:0] cpu_rddata,
    output logic              dram_req,
    output logic              dram_rnw,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [1:0]        dram_bsel,
    output logic [DATA_W-1:0] dram_wrdata,
    input  logic [DATA_W-1:0] dram_rddata
);

    typedef enum logic [1:0] {
        TGT_IDLE  = 2'd0,
        TGT_VIDEO = 2'd1,
        TGT_CPU   = 2'd2
    } tgt_t;

    tgt_t              r_cur_tgt;
    tgt_t              w_next_tgt;
    logic [2:0]        r_slot_cnt;
    logic              w_slot_hit;
    logic              w_video_slot;

    logic              r_video_next;
    logic              r_video_strobe;
    logic [DATA_W-1:0] r_video_data;
    logic              r_cpu_next;
    logic              r_cpu_strobe;
    logic [DATA_W-1:0] r_cpu_rddata;
    logic              r_dram_req;
    logic              r_dram_rnw;
    logic [ADDR_W-1:0] r_dram_addr;
    logic [1:0]        r_dram_bsel;
    logic [DATA_W-1:0] r_dram_wrdata;

    // Video slot selection uses the slot count before this cend's increment.
    always_comb begin
        w_slot_hit = 1'b1;
        case (video_bw)
            2'b00:   w_slot_hit = (r_slot_cnt == 3'd7);
            2'b01:   w_slot_hit = (r_slot_cnt[1:0] == 2'd3);
            2'b10:   w_slot_hit = r_slot_cnt[0];
            default: w_slot_hit = 1'b1;
        endcase
        w_video_slot = video_go & w_slot_hit;
    end

    // Next-target decision: video first, then CPU, otherwise idle.
    always_comb begin
        w_next_tgt = r_cur_tgt;
        if (cend) begin
            if (w_video_slot) begin
                w_next_tgt = TGT_VIDEO;
            end else if (cpu_req) begin
                w_next_tgt = TGT_CPU;
            end else begin
                w_next_tgt = TGT_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_tgt <= TGT_IDLE;
        end else begin
            r_cur_tgt <= w_next_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_cnt <= 3'd0;
        end else if (cend) begin
            r_slot_cnt <= video_go ? r_slot_cnt + 3'd1 : 3'd0;
        end
    end

    // Registered outputs. Pulses default low every clk; completion of the
    // cycle that is ending is handled before the new grant is loaded, using
    // the still-current target and direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_video_next   <= 1'b0;
            r_video_strobe <= 1'b0;
            r_video_data   <= '0;
            r_cpu_next     <= 1'b0;
            r_cpu_strobe   <= 1'b0;
            r_cpu_rddata   <= '0;
            r_dram_req     <= 1'b0;
            r_dram_rnw     <= 1'b1;
            r_dram_addr    <= '0;
            r_dram_bsel    <= 2'b11;
            r_dram_wrdata  <= '0;
        end else begin
            r_video_next   <= 1'b0;
            r_video_strobe <= 1'b0;
            r_cpu_next     <= 1'b0;
            r_cpu_strobe   <= 1'b0;
            if (cend) begin
                if (r_cur_tgt == TGT_VIDEO) begin
                    r_video_data   <= dram_rddata;
                    r_video_strobe <= 1'b1;
                end else if ((r_cur_tgt == TGT_CPU) && r_dram_rnw) begin
                    r_cpu_rddata <= dram_rddata;
                    r_cpu_strobe <= 1'b1;
                end

                case (w_next_tgt)
                    TGT_VIDEO: begin
                        r_dram_req   <= 1'b1;
                        r_dram_rnw   <= 1'b1;
                        r_dram_addr  <= video_addr;
                        r_dram_bsel  <= 2'b11;
                        r_video_next <= 1'b1;
                    end
                    TGT_CPU: begin
                        r_dram_req    <= 1'b1;
                        r_dram_rnw    <= cpu_rnw;
                        r_dram_addr   <= cpu_addr;
                        r_dram_bsel   <= cpu_rnw ? 2'b11 : cpu_bsel;
                        r_dram_wrdata <= cpu_wrdata;
                        r_cpu_next    <= 1'b1;
                    end
                    default: begin
                        r_dram_req <= 1'b0;
                        r_dram_rnw <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign video_next   = r_video_next;
    assign video_strobe = r_video_strobe;
    assign video_data   = r_video_data;
    assign cpu_next     = r_cpu_next;
    assign cpu_strobe   = r_cpu_strobe;
    assign cpu_rddata   = r_cpu_rddata;
    assign dram_req     = r_dram_req;
    assign dram_rnw     = r_dram_rnw;
    assign dram_addr    = r_dram_addr;
    assign dram_bsel    = r_dram_bsel;
    assign dram_wrdata  = r_dram_wrdata;

endmodule
`default_nettype wire

// File: tb/tb_video_dram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_dram_arb
//  Purpose  : Randomized self-checking bench for video_dram_arb against a
//             cycle-level behavioural model of the arbitration rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_video_dram_arb;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 16;
    localparam int T_IDLE = 0;
    localparam int T_VID  = 1;
    localparam int T_CPU  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cend;
    logic              video_go;
    logic [1:0]        video_bw;
    logic [ADDR_W-1:0] video_addr;
    logic              video_next;
    logic              video_strobe;
    logic [DATA_W-1:0] video_data;
    logic              cpu_req;
    logic              cpu_rnw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [1:0]        cpu_bsel;
    logic [DATA_W-1:0] cpu_wrdata;
    logic              cpu_next;
    logic              cpu_strobe;
    logic [DATA_W-1:0] cpu_rddata;
    logic              dram_req;
    logic              dram_rnw;
    logic [ADDR_W-1:0] dram_addr;
    logic [1:0]        dram_bsel;
    logic [DATA_W-1:0] dram_wrdata;
    logic [DATA_W-1:0] dram_rddata;

    video_dram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cend         (cend),
        .video_go     (video_go),
        .video_bw     (video_bw),
        .video_addr   (video_addr),
        .video_next   (video_next),
        .video_strobe (video_strobe),
        .video_data   (video_data),
        .cpu_req      (cpu_req),
        .cpu_rnw      (cpu_rnw),
        .cpu_addr     (cpu_addr),
        .cpu_bsel     (cpu_bsel),
        .cpu_wrdata   (cpu_wrdata),
        .cpu_next     (cpu_next),
        .cpu_strobe   (cpu_strobe),
        .cpu_rddata   (cpu_rddata),
        .dram_req     (dram_req),
        .dram_rnw     (dram_rnw),
        .dram_addr    (dram_addr),
        .dram_bsel    (dram_bsel),
        .dram_wrdata  (dram_wrdata),
        .dram_rddata  (dram_rddata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: slot position, owner of the cycle in flight, and the
    // expected value of every DUT output after the coming edge.
    int                m_slot;
    int                m_tgt;
    logic              e_vnext, e_vstb, e_cnext, e_cstb;
    logic [DATA_W-1:0] e_vdata, e_cdata, e_wdata;
    logic              e_req, e_rnw;
    logic [ADDR_W-1:0] e_addr;
    logic [1:0]        e_bsel;
    int                n_vnext = 0;
    int                n_cnext = 0;
    int                gap     = 0;
    logic              cpu_granted = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applies the arbitration rules to the inputs that the next edge sees.
    task automatic model_step();
        int  per;
        bit  vs;
        if (rst) begin
            m_slot = 0; m_tgt = T_IDLE;
            e_vnext = 0; e_vstb = 0; e_cnext = 0; e_cstb = 0;
            e_vdata = '0; e_cdata = '0; e_wdata = '0;
            e_req = 0; e_rnw = 1; e_addr = '0; e_bsel = 2'b11;
            return;
        end
        e_vnext = 0; e_vstb = 0; e_cnext = 0; e_cstb = 0;
        if (!cend) return;
        if (m_tgt == T_VID) begin
            e_vdata = dram_rddata; e_vstb = 1;
        end else if (m_tgt == T_CPU && e_rnw) begin
            e_cdata = dram_rddata; e_cstb = 1;
        end
        // Video owns one cycle out of every 8, 4, 2 or 1: the last of each group.
        per    = 8 >> int'(video_bw);
        vs     = video_go && ((m_slot % per) == per - 1);
        m_slot = video_go ? (m_slot + 1) % 8 : 0;
        if (vs) begin
            m_tgt = T_VID; e_req = 1; e_rnw = 1; e_addr = video_addr; e_bsel = 2'b11;
            e_vnext = 1; n_vnext++;
        end else if (cpu_req) begin
            m_tgt = T_CPU; e_req = 1; e_rnw = cpu_rnw; e_addr = cpu_addr;
            e_bsel = cpu_rnw ? 2'b11 : cpu_bsel; e_wdata = cpu_wrdata;
            e_cnext = 1; n_cnext++; cpu_granted = 1'b1;
        end else begin
            m_tgt = T_IDLE; e_req = 0; e_rnw = 1;
        end
    endtask

    task automatic check_outputs();
        chk("video_next",   32'(video_next),   32'(e_vnext));
        chk("video_strobe", 32'(video_strobe), 32'(e_vstb));
        chk("video_data",   32'(video_data),   32'(e_vdata));
        chk("cpu_next",     32'(cpu_next),     32'(e_cnext));
        chk("cpu_strobe",   32'(cpu_strobe),   32'(e_cstb));
        chk("cpu_rddata",   32'(cpu_rddata),   32'(e_cdata));
        chk("dram_req",     32'(dram_req),     32'(e_req));
        chk("dram_rnw",     32'(dram_rnw),     32'(e_rnw));
        chk("dram_addr",    32'(dram_addr),    32'(e_addr));
        chk("dram_bsel",    32'(dram_bsel),    32'(e_bsel));
        chk("dram_wrdata",  32'(dram_wrdata),  32'(e_wdata));
    endtask

    // per: cend period in clks (0 = random 1..5); bw < 0: randomly changing.
    task automatic run_phase(input int n, input int per, input int bw, input int go_pct,
                             input int req_pct, input int rnw_pct, input int rst_pct);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) < rst_pct);
            if (gap == 0) begin
                cend = 1'b1;
                gap  = (per > 0) ? per - 1 : int'($urandom_range(0, 4));
            end else begin
                cend = 1'b0;
                gap--;
            end
            if (bw >= 0) video_bw = 2'(bw);
            else if ($urandom_range(0, 15) == 0) video_bw = 2'($urandom);
            if (go_pct >= 100) video_go = 1'b1;
            else if (go_pct <= 0) video_go = 1'b0;
            else if ($urandom_range(0, 15) == 0) video_go = ($urandom_range(0, 99) < go_pct);
            video_addr  = ADDR_W'($urandom);
            dram_rddata = DATA_W'($urandom);
            // CPU request is a level held until accepted.
            if (!cpu_req || cpu_granted) begin
                cpu_granted = 1'b0;
                cpu_req     = ($urandom_range(0, 99) < req_pct);
                cpu_rnw     = ($urandom_range(0, 99) < rnw_pct);
                cpu_addr    = ADDR_W'($urandom);
                cpu_bsel    = 2'($urandom);
                cpu_wrdata  = DATA_W'($urandom);
            end
            model_step();
            @(posedge clk);
            #1;
            check_outputs();
        end
    endtask

    initial begin
        rst = 1'b1; cend = 1'b0; video_go = 1'b0; video_bw = 2'b00;
        video_addr = '0; cpu_req = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0;
        cpu_bsel = 2'b11; cpu_wrdata = '0; dram_rddata = '0;

        // Reset state, including a cend coincident with reset.
        run_phase(4, 2, 0, 0, 0, 100, 100);

        // Video only, bw=00, cend every 4 clk: one grant per 8 cends.
        gap = 0; n_vnext = 0;
        run_phase(8 * 32 + 8, 4, 0, 100, 0, 100, 0);
        chk("bw00_grants", 32'(n_vnext), 32'd8);

        // bw=01 with CPU reads pending: CPU,CPU,CPU,VIDEO per 4 cends.
        run_phase(4, 2, 0, 0, 0, 100, 100);
        gap = 0; n_vnext = 0; n_cnext = 0;
        run_phase(4 * 40, 4, 1, 100, 100, 100, 0);
        chk("bw01_video", 32'(n_vnext), 32'd10);
        chk("bw01_cpu",   32'(n_cnext), 32'd30);

        // CPU writes against bw=00 video, including collisions at slot 7.
        run_phase(600, 3, 0, 100, 100, 0, 0);

        // Back-to-back cends with bw=11 and a competing CPU.
        run_phase(200, 1, 3, 100, 80, 50, 0);

        // Everything random, with video_go toggling and sporadic resets.
        run_phase(3000, 0, -1, 70, 60, 50, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
